// File: rtl/hls8x2_3_pkg.sv
// Shared types and constants for the HLS8x2 stage-3 product accumulator.
// Holds the accumulator state enum, the default datapath widths shared with
// the multiplier stage, and a constant-evaluable ceil(log2) helper.
package hls8x2_3_pkg;

   typedef enum logic {
      S_ACC = 1'b0,   // collecting products
      S_OUT = 1'b1    // holding a result for the consumer
   } state_e;

   localparam int IN_WIDTH_DEF  = 16;
   localparam int OUT_WIDTH_DEF = 16;

   // ceil(log2(v)); returns 0 for v <= 1. Bounded loop so it elaborates cleanly.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hls8x2_3_sat.sv
// Signed saturation from ACC_WIDTH down to OUT_WIDTH bits.
// Latency: combinational. Backpressure: none (pure function of x).
// Ports: x (signed ACC_WIDTH in), y (clipped signed OUT_WIDTH out), sat (1 when clipped).
module hls8x2_3_sat #(
   parameter int ACC_WIDTH = 24,
   parameter int OUT_WIDTH = 16
) (
   input  logic signed [ACC_WIDTH-1:0] x,
   output logic signed [OUT_WIDTH-1:0] y,
   output logic                        sat
);

   // x fits in OUT_WIDTH iff every bit from the output sign bit upward
   // equals the input sign bit.
   logic [ACC_WIDTH-OUT_WIDTH:0] hi_bits;
   logic                         fits;

   assign hi_bits = x[ACC_WIDTH-1:OUT_WIDTH-1];
   assign fits    = (&hi_bits) | ~(|hi_bits);

   always_comb begin
      y   = x[OUT_WIDTH-1:0];
      sat = 1'b0;
      if (!fits) begin
         sat = 1'b1;
         // Negative overflow -> most negative value, positive -> most positive.
         y   = {x[ACC_WIDTH-1], {(OUT_WIDTH-1){~x[ACC_WIDTH-1]}}};
      end
   end

endmodule

// File: rtl/hls8x2_3_prod_accum.sv
// Sums VEC_LEN signed products into a wide accumulator, emits saturated result.
// Latency: sum_vld rises the cycle after the VEC_LEN-th accepted product.
// Backpressure: prod_ack drops while a result waits for sum_ack (one bubble per result).
// Ports: ap_clk/ap_rst (sync active-high); prod_V/prod_vld/prod_ack input handshake;
//        sum_V/sum_sat/sum_vld/sum_ack held output handshake.
module hls8x2_3_prod_accum
   import hls8x2_3_pkg::*;
#(
   parameter int IN_WIDTH  = IN_WIDTH_DEF,
   parameter int VEC_LEN   = 8,
   parameter int ACC_WIDTH = 24,
   parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst,
   input  logic signed [IN_WIDTH-1:0]  prod_V,
   input  logic                        prod_vld,
   output logic                        prod_ack,
   output logic signed [OUT_WIDTH-1:0] sum_V,
   output logic                        sum_sat,
   output logic                        sum_vld,
   input  logic                        sum_ack
);

   // Counter needs at least one bit even when VEC_LEN is 1.
   localparam int CNT_W = (clog2(VEC_LEN) < 1) ? 1 : clog2(VEC_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

   state_e                        state_q;
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic        [CNT_W-1:0]       cnt_q;
   logic signed [OUT_WIDTH-1:0]   sum_q;
   logic                          sat_q;

   logic signed [ACC_WIDTH-1:0]   prod_ext;
   logic signed [ACC_WIDTH-1:0]   acc_d;
   logic signed [OUT_WIDTH-1:0]   sum_d;
   logic                          sat_d;

   // Size cast of a signed operand sign-extends; width rule rules out overflow.
   assign prod_ext = ACC_WIDTH'(prod_V);
   assign acc_d    = acc_q + prod_ext;

   hls8x2_3_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH)
   ) u_sat (
      .x   (acc_d),
      .y   (sum_d),
      .sat (sat_d)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= S_ACC;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         case (state_q)
            S_ACC: begin
               // prod_ack is 1 throughout S_ACC, so prod_vld alone marks a transfer.
               if (prod_vld) begin
                  if (cnt_q == CNT_LAST) begin
                     sum_q   <= sum_d;
                     sat_q   <= sat_d;
                     acc_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= S_OUT;
                  end else begin
                     acc_q <= acc_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            S_OUT: begin
               if (sum_ack) state_q <= S_ACC;
            end
            default: state_q <= S_ACC;
         endcase
      end
   end

   // Handshake outputs decode the state register only: no input-to-output path.
   assign prod_ack = (state_q == S_ACC);
   assign sum_vld  = (state_q == S_OUT);
   assign sum_V    = sum_q;
   assign sum_sat  = sat_q;

endmodule

// File: tb/tb_hls8x2_3_prod_accum.sv
module tb_hls8x2_3_prod_accum;

   localparam int IW = 16;
   localparam int VL = 8;
   localparam int AW = 24;
   localparam int OW = 16;

   logic                 ap_clk = 1'b0;
   logic                 ap_rst;
   logic signed [IW-1:0] prod_V;
   logic                 prod_vld;
   logic                 prod_ack;
   logic signed [OW-1:0] sum_V;
   logic                 sum_sat;
   logic                 sum_vld;
   logic                 sum_ack;

   int total = 0;
   int bad   = 0;
   int vec[VL];

   always #5 ap_clk = ~ap_clk;

   hls8x2_3_prod_accum #(
      .IN_WIDTH  (IW),
      .VEC_LEN   (VL),
      .ACC_WIDTH (AW),
      .OUT_WIDTH (OW)
   ) dut (
      .ap_clk   (ap_clk),
      .ap_rst   (ap_rst),
      .prod_V   (prod_V),
      .prod_vld (prod_vld),
      .prod_ack (prod_ack),
      .sum_V    (sum_V),
      .sum_sat  (sum_sat),
      .sum_vld  (sum_vld),
      .sum_ack  (sum_ack)
   );

   // Reference: exact integer dot-product, then clip to the signed output range.
   function automatic longint ref_sum(input int n);
      longint s = 0;
      for (int i = 0; i < n; i++) s += vec[i];
      return s;
   endfunction

   function automatic longint ref_clip(input longint s);
      longint hi = (longint'(1) <<< (OW - 1)) - 1;
      longint lo = -(longint'(1) <<< (OW - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

   // Drives n products from vec[] with random 0..gap_max idle cycles before each.
   // Leaves prod_vld high after the last transfer; ok=0 if prod_ack never came.
   task automatic send_vector(input int n, input int gap_max, output bit ok);
      ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         int g;
         int w;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         if (g > 0) begin
            prod_vld = 1'b0;
            repeat (g) begin @(posedge ap_clk); #1; end
         end
         prod_V   = IW'(vec[i]);
         prod_vld = 1'b1;
         w = 0;
         while (prod_ack !== 1'b1 && w < 50) begin @(posedge ap_clk); #1; w++; end
         if (w >= 50) ok = 1'b0;
         @(posedge ap_clk); #1;
      end
   endtask

   task automatic release_result();
      sum_ack = 1'b1;
      @(posedge ap_clk); #1;
      sum_ack = 1'b0;
   endtask

   task automatic test_reset();
      ap_rst = 1'b1; prod_vld = 1'b0; prod_V = '0; sum_ack = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1 ap_rst = 1'b0;
      total++; if (prod_ack !== 1'b1) begin bad++; $display("FAIL reset_prod_ack got=%b want=1", prod_ack); end
      total++; if (sum_vld  !== 1'b0) begin bad++; $display("FAIL reset_sum_vld got=%b want=0", sum_vld); end
      total++; if (sum_V    !== '0)   begin bad++; $display("FAIL reset_sum_V got=%0d want=0", sum_V); end
      total++; if (sum_sat  !== 1'b0) begin bad++; $display("FAIL reset_sum_sat got=%b want=0", sum_sat); end
   endtask

   task automatic test_basic();
      bit ok;
      for (int i = 0; i < VL; i++) vec[i] = i + 1;
      total++; if (sum_vld !== 1'b0) begin bad++; $display("FAIL basic_pre_vld got=%b want=0", sum_vld); end
      send_vector(VL, 0, ok);
      prod_vld = 1'b0;
      total++; if (!ok)               begin bad++; $display("FAIL basic_timeout got=0 want=1"); end
      total++; if (sum_vld !== 1'b1)  begin bad++; $display("FAIL basic_vld got=%b want=1", sum_vld); end
      total++; if (prod_ack !== 1'b0) begin bad++; $display("FAIL basic_prod_ack got=%b want=0", prod_ack); end
      total++; if (sum_V !== 16'sd36) begin bad++; $display("FAIL basic_sum got=%0d want=36", sum_V); end
      total++; if (sum_sat !== 1'b0)  begin bad++; $display("FAIL basic_sat got=%b want=0", sum_sat); end
      release_result();
      total++; if (sum_vld !== 1'b0 || prod_ack !== 1'b1) begin
         bad++; $display("FAIL basic_release got vld=%b ack=%b want vld=0 ack=1", sum_vld, prod_ack);
      end
   endtask

   // One test per fixed-pattern vector: fills vec with a, then b for the last half.
   task automatic test_pattern(input string name, input int a, input int b);
      bit ok;
      longint s;
      for (int i = 0; i < VL; i++) vec[i] = (i < VL / 2) ? a : b;
      s = ref_sum(VL);
      send_vector(VL, 0, ok);
      prod_vld = 1'b0;
      total++; if (!ok || sum_vld !== 1'b1) begin bad++; $display("FAIL %s_vld got=%b want=1", name, sum_vld); end
      total++; if (sum_V !== OW'(ref_clip(s))) begin
         bad++; $display("FAIL %s_sum got=%0d want=%0d", name, sum_V, ref_clip(s));
      end
      total++; if (sum_sat !== (ref_clip(s) != s)) begin
         bad++; $display("FAIL %s_sat got=%b want=%b", name, sum_sat, ref_clip(s) != s);
      end
      release_result();
   endtask

   task automatic test_backpressure();
      bit ok;
      logic signed [OW-1:0] held;
      for (int i = 0; i < VL; i++) vec[i] = 1000 * (i + 1);
      send_vector(VL, 0, ok);
      held = sum_V;
      total++; if (!ok || held !== 16'sd32767 || sum_sat !== 1'b1) begin
         bad++; $display("FAIL bp_first got=%0d sat=%b want=32767 sat=1", held, sum_sat);
      end
      // Producer keeps offering -1 while the consumer stalls.
      prod_V = -16'sd1; prod_vld = 1'b1;
      for (int c = 0; c < 10; c++) begin
         total++; if (sum_vld !== 1'b1 || prod_ack !== 1'b0 || sum_V !== held) begin
            bad++; $display("FAIL bp_hold cyc=%0d got vld=%b ack=%b sum=%0d want vld=1 ack=0 sum=%0d",
                            c, sum_vld, prod_ack, sum_V, held);
         end
         @(posedge ap_clk); #1;
      end
      prod_vld = 1'b0;
      release_result();
      total++; if (prod_ack !== 1'b1) begin bad++; $display("FAIL bp_ack_after got=%b want=1", prod_ack); end
      for (int i = 0; i < VL; i++) vec[i] = -1;
      send_vector(VL, 0, ok);
      prod_vld = 1'b0;
      total++; if (!ok || sum_vld !== 1'b1 || sum_V !== -16'sd8 || sum_sat !== 1'b0) begin
         bad++; $display("FAIL bp_second got=%0d sat=%b want=-8 sat=0", sum_V, sum_sat);
      end
      release_result();
   endtask

   task automatic test_gapped();
      bit ok;
      for (int i = 0; i < VL; i++) vec[i] = i + 1;
      sum_ack = 1'b1;   // held high while accumulating; must not disturb anything
      send_vector(VL, 3, ok);
      prod_vld = 1'b0;
      total++; if (!ok || sum_vld !== 1'b1 || sum_V !== 16'sd36 || sum_sat !== 1'b0) begin
         bad++; $display("FAIL gapped_sum got vld=%b sum=%0d sat=%b want vld=1 sum=36 sat=0", sum_vld, sum_V, sum_sat);
      end
      @(posedge ap_clk); #1;
      sum_ack = 1'b0;
      total++; if (sum_vld !== 1'b0 || prod_ack !== 1'b1) begin
         bad++; $display("FAIL gapped_release got vld=%b ack=%b want vld=0 ack=1", sum_vld, prod_ack);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int i = 0; i < VL; i++) vec[i] = 50;
      send_vector(5, 0, ok);
      prod_vld = 1'b0;
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      for (int i = 0; i < VL; i++) vec[i] = 3;
      send_vector(VL, 1, ok);
      prod_vld = 1'b0;
      total++; if (!ok || sum_vld !== 1'b1 || sum_V !== 16'sd24) begin
         bad++; $display("FAIL rst_mid_sum got vld=%b sum=%0d want vld=1 sum=24", sum_vld, sum_V);
      end
      // Reset while a result is pending drops it.
      ap_rst = 1'b1;
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      total++; if (sum_vld !== 1'b0 || prod_ack !== 1'b1 || sum_V !== '0) begin
         bad++; $display("FAIL rst_out got vld=%b ack=%b sum=%0d want vld=0 ack=1 sum=0", sum_vld, prod_ack, sum_V);
      end
   endtask

   task automatic test_random();
      bit ok;
      longint s;
      for (int v = 0; v < 20; v++) begin
         for (int i = 0; i < VL; i++) begin
            if (v % 2 == 0) vec[i] = int'($signed(16'($urandom)));
            else            vec[i] = int'($urandom_range(8000, 0)) - 4000;
         end
         s = ref_sum(VL);
         send_vector(VL, 2, ok);
         prod_vld = 1'b0;
         repeat ($urandom_range(3, 0)) begin
            total++; if (sum_vld !== 1'b1 || prod_ack !== 1'b0) begin
               bad++; $display("FAIL rand_hold v=%0d got vld=%b ack=%b want vld=1 ack=0", v, sum_vld, prod_ack);
            end
            @(posedge ap_clk); #1;
         end
         total++; if (!ok || sum_vld !== 1'b1 || sum_V !== OW'(ref_clip(s)) || sum_sat !== (ref_clip(s) != s)) begin
            bad++; $display("FAIL rand_vec v=%0d got vld=%b sum=%0d sat=%b want vld=1 sum=%0d sat=%b",
                            v, sum_vld, sum_V, sum_sat, ref_clip(s), ref_clip(s) != s);
         end
         release_result();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pattern("pos_sat", 16'sh7000, 16'sh7000);
      test_pattern("neg_sat", -28672, -28672);
      test_pattern("cancel", 100, -100);
      test_backpressure();
      test_gapped();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
